// File: rtl/nonce_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : nonce_result_checker
// Purpose  : Reads back the per-nonce first-word hash results and finds the
//            minimum word and its nonce index. It also counts the words that
//            are strictly below a 32-bit target. A 3-word report is written
//            back to memory, and the same results are held on ports.
// Ports    : clk, reset (sync, active-high), start, result_addr,
//            report_addr, target, done, mem_clk, mem_we, mem_addr,
//            mem_write_data, mem_read_data, found, match_count, best_nonce,
//            best_value
// Options  : NONCE_CHECK_BYTESWAP_EN - when defined, the min and target
//            comparisons use the byte-reversed read word. The reported
//            best_value stays the raw memory word.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_result_checker #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [15:0] report_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [7:0]  match_count,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_value
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    localparam logic [8:0] c_LAST_K   = 9'(NUM_NONCES);
    localparam logic [8:0] c_LAST_IDX = 9'(NUM_NONCES - 1);

    logic [1:0]  r_state;
    logic [8:0]  r_k;
    logic [1:0]  r_w;
    logic [15:0] r_result_addr;
    logic [15:0] r_report_addr;
    logic [31:0] r_target;

    // Running accumulators for the current scan. The comparison key is kept
    // separately from the raw word so the byte-swap option only affects the
    // ordering, not the value reported.
    logic [31:0] r_min_key;
    logic [31:0] r_min_raw;
    logic [7:0]  r_min_idx;
    logic [7:0]  r_count;

    logic        r_found;
    logic [7:0]  r_match_count;
    logic [7:0]  r_best_nonce;
    logic [31:0] r_best_value;

    logic [31:0] w_key;
    logic        w_sample;
    logic        w_take_min;
    logic        w_is_match;
    logic [7:0]  w_idx;
    logic [31:0] w_min_key_n;
    logic [31:0] w_min_raw_n;
    logic [7:0]  w_min_idx_n;
    logic [7:0]  w_count_n;
    logic [15:0] w_rd_off;

`ifdef NONCE_CHECK_BYTESWAP_EN
    assign w_key = {mem_read_data[7:0], mem_read_data[15:8],
                    mem_read_data[23:16], mem_read_data[31:24]};
`else
    assign w_key = mem_read_data;
`endif

    // The read data lags the address by one cycle, so the word for nonce k-1
    // arrives during READ step k. Step 0 only issues the first address.
    assign w_sample   = (r_state == c_READ) && (r_k != 9'd0);
    assign w_idx      = 8'(r_k - 9'd1);
    assign w_take_min = w_sample && ((r_k == 9'd1) || (w_key < r_min_key));
    assign w_is_match = w_sample && (w_key < r_target);

    assign w_min_key_n = w_take_min ? w_key         : r_min_key;
    assign w_min_raw_n = w_take_min ? mem_read_data : r_min_raw;
    assign w_min_idx_n = w_take_min ? w_idx         : r_min_idx;
    assign w_count_n   = r_count + (w_is_match ? 8'd1 : 8'd0);

    // The final READ step only collects the last word. The address is held
    // on the last result word, so no read goes past the result block.
    assign w_rd_off = (r_k > c_LAST_IDX) ? 16'(c_LAST_IDX) : 16'(r_k);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_k           <= 9'd0;
            r_w           <= 2'd0;
            r_result_addr <= 16'd0;
            r_report_addr <= 16'd0;
            r_target      <= 32'd0;
            r_min_key     <= 32'hFFFF_FFFF;
            r_min_raw     <= 32'hFFFF_FFFF;
            r_min_idx     <= 8'd0;
            r_count       <= 8'd0;
            r_found       <= 1'b0;
            r_match_count <= 8'd0;
            r_best_nonce  <= 8'd0;
            r_best_value  <= 32'hFFFF_FFFF;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_result_addr <= result_addr;
                        r_report_addr <= report_addr;
                        r_target      <= target;
                        r_k           <= 9'd0;
                        r_w           <= 2'd0;
                        r_min_key     <= 32'hFFFF_FFFF;
                        r_min_raw     <= 32'hFFFF_FFFF;
                        r_min_idx     <= 8'd0;
                        r_count       <= 8'd0;
                        r_state       <= c_READ;
                    end
                end
                c_READ: begin
                    r_min_key <= w_min_key_n;
                    r_min_raw <= w_min_raw_n;
                    r_min_idx <= w_min_idx_n;
                    r_count   <= w_count_n;
                    if (r_k == c_LAST_K) begin
                        // Publish the results that include the last word
                        // sampled in this same step.
                        r_found       <= (w_count_n != 8'd0);
                        r_match_count <= w_count_n;
                        r_best_nonce  <= w_min_idx_n;
                        r_best_value  <= w_min_raw_n;
                        r_w           <= 2'd0;
                        r_state       <= c_WRITE;
                    end else begin
                        r_k <= r_k + 9'd1;
                    end
                end
                c_WRITE: begin
                    r_w <= r_w + 2'd1;
                    if (r_w == 2'd2) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr       = 16'd0;
        mem_write_data = 32'd0;
        case (r_state)
            c_READ:  mem_addr = r_result_addr + w_rd_off;
            c_WRITE: begin
                mem_addr = r_report_addr + {14'd0, r_w};
                case (r_w)
                    2'd0:    mem_write_data = {r_found, 23'd0, r_match_count};
                    2'd1:    mem_write_data = {24'd0, r_best_nonce};
                    2'd2:    mem_write_data = r_best_value;
                    default: mem_write_data = 32'd0;
                endcase
            end
            default: ;
        endcase
    end

    assign mem_we      = (r_state == c_WRITE);
    assign done        = (r_state == c_IDLE);
    assign mem_clk     = clk;
    assign found       = r_found;
    assign match_count = r_match_count;
    assign best_nonce  = r_best_nonce;
    assign best_value  = r_best_value;

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_result_checker
// Purpose  : Self-checking bench for nonce_result_checker. It applies a table
//            of directed scans, then a reset-during-scan sequence, then
//            randomized scans. Random scans are compared against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_result_checker;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] result_addr = 16'd0;
    logic [15:0] report_addr = 16'd0;
    logic [31:0] target = 32'd0;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        found;
    logic [7:0]  match_count;
    logic [7:0]  best_nonce;
    logic [31:0] best_value;

    nonce_result_checker #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .result_addr(result_addr), .report_addr(report_addr), .target(target),
        .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .found(found), .match_count(match_count), .best_nonce(best_nonce),
        .best_value(best_value)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory: the read data appears one cycle after
    // the address.
    logic [31:0] mem [0:65535];
    always @(posedge mem_clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_write_data;
    end

    // Bus monitor: counts write cycles and logs every read address.
    int           we_total = 0;
    logic [15:0]  rd_q[$];
    always @(negedge clk) begin
        if (mem_we) we_total++;
        if (!done && !mem_we) rd_q.push_back(mem_addr);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    logic [31:0] vals [N];

    function automatic logic [31:0] cmp_key(input logic [31:0] v);
`ifdef NONCE_CHECK_BYTESWAP_EN
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
        return v;
`endif
    endfunction

    // Reference model. The count is the number of keys below the target.
    // The best nonce is the first index that holds the smallest key.
    task automatic model(input logic [31:0] tgt, output logic f, output logic [7:0] cnt,
                         output logic [7:0] nonce, output logic [31:0] val);
        int c = 0;
        int bi = 0;
        for (int i = 0; i < N; i++) if (cmp_key(vals[i]) < tgt) c++;
        for (int i = 1; i < N; i++) if (cmp_key(vals[i]) < cmp_key(vals[bi])) bi = i;
        f = (c != 0); cnt = 8'(c); nonce = 8'(bi); val = vals[bi];
    endtask

    task automatic launch(input logic [15:0] ra, input logic [15:0] pa, input logic [31:0] tgt);
        for (int i = 0; i < N; i++) mem[16'(ra + 16'(i))] = vals[i];
        for (int i = 0; i < 3; i++) mem[16'(pa + 16'(i))] = 32'hDEAD_BEEF;
        @(negedge clk);
        result_addr = ra; report_addr = pa; target = tgt; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic scan_and_check(input string tag, input logic [15:0] ra, input logic [15:0] pa,
                                  input logic [31:0] tgt, input logic ef, input logic [7:0] ecnt,
                                  input logic [7:0] enonce, input logic [31:0] eval);
        int lat = 0;
        int s;
        int bad = 0;
        s = rd_q.size();
        launch(ra, pa, tgt);
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check({tag, " latency"}, lat, N + 4);
        check({tag, " found"}, {31'd0, found}, {31'd0, ef});
        check({tag, " match_count"}, {24'd0, match_count}, {24'd0, ecnt});
        check({tag, " best_nonce"}, {24'd0, best_nonce}, {24'd0, enonce});
        check({tag, " best_value"}, best_value, eval);
        check({tag, " report0"}, mem[pa], {ef, 23'd0, ecnt});
        check({tag, " report1"}, mem[16'(pa + 16'd1)], {24'd0, enonce});
        check({tag, " report2"}, mem[16'(pa + 16'd2)], eval);
        check({tag, " read count"}, rd_q.size() - s, N + 1);
        for (int k = 0; k <= N && s + k < rd_q.size(); k++)
            if (rd_q[s + k] != 16'(ra + 16'((k < N) ? k : N - 1))) bad++;
        check({tag, " read addrs bad"}, bad, 0);
    endtask

    function automatic logic [31:0] pat_val(input int pat, input int i);
        case (pat)
            0: return 32'(100 + i);
            1: return (i == 7 || i == 12) ? 32'h10 : 32'hFFFF_FFF0;
            2: return 32'hFFFF_FFFF;
            3: return 32'(i);
            4: return {4{8'(20 - i)}};
            default: return (i == 3) ? 32'h0100_0000 : 32'h2;
        endcase
    endfunction

    typedef struct {
        int          pat;
        logic [15:0] ra;
        logic [15:0] pa;
        logic [31:0] tgt;
        logic        f;
        logic [7:0]  cnt;
        logic [7:0]  nonce;
        logic [31:0] val;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic        mf;
        logic [7:0]  mcnt, mnonce;
        logic [31:0] mval, tgt;
        logic [15:0] ra;
        int          w0;

        // Words 100..115 with a target of 105 give five matches and a
        // minimum of 0x64.
        tbl[0] = '{0, 16'h0040, 16'h0080, 32'd105,        1'b1, 8'd5,  8'd0,  32'h64};
        tbl[1] = '{1, 16'h0100, 16'h0180, 32'h10,         1'b0, 8'd0,  8'd7,  32'h10};
        tbl[2] = '{2, 16'h0200, 16'h0280, 32'h0,          1'b0, 8'd0,  8'd0,  32'hFFFF_FFFF};
        tbl[3] = '{3, 16'h0300, 16'h0380, 32'hFFFF_FFFF,  1'b1, 8'd16, 8'd0,  32'h0};
        tbl[4] = '{4, 16'hFFF8, 16'h0400, 32'h0808_0808,  1'b1, 8'd3,  8'd15, 32'h0505_0505};
`ifdef NONCE_CHECK_BYTESWAP_EN
        tbl[5] = '{5, 16'h0500, 16'h0580, 32'h3,          1'b1, 8'd1,  8'd3,  32'h0100_0000};
`else
        tbl[5] = '{5, 16'h0500, 16'h0580, 32'h3,          1'b1, 8'd15, 8'd0,  32'h2};
`endif

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        w0 = we_total;
        @(negedge clk);
        check("rst done", {31'd0, done}, 32'd1);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst mem_write_data", mem_write_data, 32'd0);
        check("rst found", {31'd0, found}, 32'd0);
        check("rst match_count", {24'd0, match_count}, 32'd0);
        check("rst best_nonce", {24'd0, best_nonce}, 32'd0);
        check("rst best_value", best_value, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        check("idle writes", we_total - w0, 0);
        check("idle done", {31'd0, done}, 32'd1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) vals[i] = pat_val(tbl[t].pat, i);
            scan_and_check($sformatf("vec%0d", t), tbl[t].ra, tbl[t].pa, tbl[t].tgt,
                           tbl[t].f, tbl[t].cnt, tbl[t].nonce, tbl[t].val);
        end

        // A reset during READ at k=8 must discard the scan. No report
        // write may happen afterwards.
        for (int i = 0; i < N; i++) vals[i] = 32'(7 + i);
        w0 = we_total;
        launch(16'h0600, 16'h0680, 32'hFFFF_FFFF);
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("midrst done", {31'd0, done}, 32'd1);
        check("midrst best_value", best_value, 32'hFFFF_FFFF);
        check("midrst match_count", {24'd0, match_count}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("midrst writes", we_total - w0, 0);
        check("midrst report0", mem[16'h0680], 32'hDEAD_BEEF);
        check("midrst report2", mem[16'h0682], 32'hDEAD_BEEF);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 3 == 0) vals[i] = $urandom;
                else            vals[i] = 32'($urandom_range(0, 40));
            end
            if (r % 4 == 1) vals[$urandom_range(0, N - 1)] = vals[$urandom_range(0, N - 1)];
            tgt = (r % 3 == 0) ? $urandom : 32'($urandom_range(0, 45));
            ra  = 16'($urandom);
            model(tgt, mf, mcnt, mnonce, mval);
            scan_and_check($sformatf("rnd%0d", r), ra, 16'(ra + 16'h1000), tgt,
                           mf, mcnt, mnonce, mval);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
